// File: rtl/dsp_mac_p.sv
// Systolic-array MAC cell: forwarded operand registers, product register, saturating
// accumulator, and a scaled/rounded/saturated drain with bubble-free restart.
module dsp_mac_p #(
  parameter int DW    = 16,
  parameter int AW    = 40,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  parameter int RND   = 0,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_value,
  input  logic [DW-1:0] b_value,
  input  logic          aen,
  input  logic          ben,
  input  logic          men,
  input  logic          sen,
  input  logic          start,
  input  logic          sreset,
  output logic [DW-1:0] a_fwd,
  output logic [DW-1:0] b_fwd,
  output logic [OW-1:0] s_out,
  output logic          sat,
  output logic          acc_sat,
  output logic [CW-1:0] cnt,
  output logic          s_valid
);

  localparam int          RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW:0] RCONST = ((RND != 0) && (SHIFT > 0)) ?
                                   ({{AW{1'b0}}, 1'b1} << RSH) : {(AW+1){1'b0}};

  function automatic logic [AW-1:0] sat_aw(input logic [AW:0] v);
    logic [AW-1:0] res;
    if (v[AW] != v[AW-1]) begin
      res = v[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      res = v[AW-1:0];
    end
    return res;
  endfunction

  // Returns {clamped, value}: clamps when the bits above the OW-bit sign are not a pure sign extension.
  function automatic logic [OW:0] sat_ow(input logic [AW:0] v);
    logic [AW-OW+1:0] upper;
    logic [OW:0]      res;
    upper = v[AW:OW-1];
    if (!((&upper) || !(|upper))) begin
      res = {1'b1, (v[AW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}})};
    end else begin
      res = {1'b0, v[OW-1:0]};
    end
    return res;
  endfunction

  logic [DW-1:0]   a_post_q, a_post_d, b_post_q, b_post_d;
  logic [2*DW-1:0] m_int_q, m_int_d, prod;
  logic [AW-1:0]   acc_q, acc_d, acc_next;
  logic            acc_sat_q, acc_sat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   s_out_q, s_out_d;
  logic            sat_q, sat_d, s_valid_q, s_valid_d;
  logic [AW:0]     m_ext, sum;
  logic            aw_clamp;
  logic signed [AW:0] rnd_sum, shifted;
  logic [OW:0]     ow_res;

  // Datapath and next-state for every register of the cell.
  always_comb begin
    prod     = {{DW{a_post_q[DW-1]}}, a_post_q} * {{DW{b_post_q[DW-1]}}, b_post_q};
    m_ext    = {{(AW+1-2*DW){m_int_q[2*DW-1]}}, m_int_q};
    sum      = {acc_q[AW-1], acc_q} + m_ext;
    aw_clamp = sen && (sum[AW] != sum[AW-1]);
    if (sen) begin
      acc_next = sat_aw(sum);
    end else begin
      acc_next = acc_q;
    end
    rnd_sum = {acc_next[AW-1], acc_next} + RCONST;
    shifted = rnd_sum >>> SHIFT;
    ow_res  = sat_ow(shifted);

    if (aen) begin
      a_post_d = a_value;
    end else begin
      a_post_d = a_post_q;
    end
    if (ben) begin
      b_post_d = b_value;
    end else begin
      b_post_d = b_post_q;
    end
    if (men) begin
      m_int_d = prod;
    end else begin
      m_int_d = m_int_q;
    end

    // A restart seeds the new run with this cycle's product so no term slot is lost.
    if (start || sreset) begin
      acc_d     = sen ? m_ext[AW-1:0] : {AW{1'b0}};
      cnt_d     = CW'(sen);
      acc_sat_d = 1'b0;
    end else if (sen) begin
      acc_d     = acc_next;
      cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CW'(1'b1);
      acc_sat_d = acc_sat_q | aw_clamp;
    end else begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      acc_sat_d = acc_sat_q;
    end

    if (sreset) begin
      s_out_d = ow_res[OW-1:0];
      sat_d   = ow_res[OW] | acc_sat_q | aw_clamp;
    end else begin
      s_out_d = s_out_q;
      sat_d   = sat_q;
    end
    s_valid_d = sreset;
  end

  // State registers; reset clears everything, including the forwarded operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_post_q  <= '0;
      b_post_q  <= '0;
      m_int_q   <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      cnt_q     <= '0;
      s_out_q   <= '0;
      sat_q     <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      a_post_q  <= a_post_d;
      b_post_q  <= b_post_d;
      m_int_q   <= m_int_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      cnt_q     <= cnt_d;
      s_out_q   <= s_out_d;
      sat_q     <= sat_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign a_fwd   = a_post_q;
  assign b_fwd   = b_post_q;
  assign s_out   = s_out_q;
  assign sat     = sat_q;
  assign acc_sat = acc_sat_q;
  assign cnt     = cnt_q;
  assign s_valid = s_valid_q;

endmodule
